// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Used by the fetch unit and its instruction queue.
package fetch_pkg;

  localparam logic [31:0] HALT_INSTR = 32'hEAFF_FFFE;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue with wrap-bit pointers.
// Push and pop may happen together even when full.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fq_entry_t wdata,
  output fq_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t     mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch feeding a small queue.
// Stops on a branch-to-self word until redirected.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        halt
);

  logic [31:0] fetch_pc;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push_en;
  fq_entry_t   wdata;
  fq_entry_t   rdata;

  assign imem_a      = fetch_pc & WORD_MASK;
  assign instr_valid = ~empty;
  assign instr       = rdata.instr;
  assign instr_pc    = rdata.pc;

  assign pop     = instr_valid & instr_ready & ~redirect;
  assign push_en = ~redirect & ~halt & (~full | pop);

  assign wdata.instr = imem_rd;
  assign wdata.pc    = fetch_pc;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push_en),
    .pop    (pop),
    .flush  (redirect),
    .wdata  (wdata),
    .rdata  (rdata),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      halt     <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & WORD_MASK;
      halt     <= 1'b0;
    end else if (push_en) begin
      // A branch-to-self parks fetch on its own address.
      if (imem_rd == HALT_INSTR) halt <= 1'b1;
      else fetch_pc <= fetch_pc + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed checks of fetch_unit against a small program image.
// Expected values are hand-derived from the program layout.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        halt;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_a     (imem_a),
    .imem_rd    (imem_rd),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .halt       (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'hE3A0_00AA;
      30'd1:   return 32'hE3A0_1055;
      30'd120: return 32'hE3A0_00FC;
      30'd122: return 32'hEAFF_FFFE;
      default: return {20'hE1A00, a[13:2]};
    endcase
  endfunction

  always_comb imem_rd = word_at(imem_a);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    #12;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_imem_a", imem_a, 32'h0);

    // Stream after reset, one per cycle.
    reset_n     = 1'b1;
    instr_ready = 1'b1;
    step();
    chk("s1_instr", instr, 32'hE3A0_00AA);
    chk("s1_pc", instr_pc, 32'h0);
    step();
    chk("s2_instr", instr, 32'hE3A0_1055);
    chk("s2_pc", instr_pc, 32'h4);
    step();
    chk("s3_pc", instr_pc, 32'h8);

    // Stall fills queue to exactly four entries.
    instr_ready = 1'b0;
    redir(32'h0);
    chk("rd0_valid", {31'd0, instr_valid}, 32'd0);
    chk("rd0_imem_a", imem_a, 32'h0);
    for (int i = 0; i < 10; i++) step();
    chk("stall_imem_a", imem_a, 32'h10);
    chk("stall_head", instr_pc, 32'h0);

    // Full queue drains one per cycle while refilling.
    instr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("drain_pc", instr_pc, 32'(4 * i));
      chk("drain_imem_a", imem_a, 32'(32'h10 + 4 * i));
      chk("drain_valid", {31'd0, instr_valid}, 32'd1);
    end

    // Redirect with three entries queued.
    instr_ready = 1'b0;
    redir(32'h0);
    for (int i = 0; i < 3; i++) step();
    chk("q3_imem_a", imem_a, 32'hC);
    instr_ready = 1'b1;
    redir(32'h1E2);
    chk("rd_valid", {31'd0, instr_valid}, 32'd0);
    chk("rd_imem_a", imem_a, 32'h1E0);
    step();
    chk("rd_instr", instr, 32'hE3A0_00FC);
    chk("rd_pc", instr_pc, 32'h1E0);

    // Run into branch-to-self.
    step();
    chk("h0_pc", instr_pc, 32'h1E4);
    chk("h0_halt", {31'd0, halt}, 32'd0);
    step();
    chk("h1_halt", {31'd0, halt}, 32'd1);
    chk("h1_imem_a", imem_a, 32'h1E8);
    chk("h1_instr", instr, 32'hEAFF_FFFE);
    chk("h1_pc", instr_pc, 32'h1E8);
    step();
    chk("h2_valid", {31'd0, instr_valid}, 32'd0);
    step();
    step();
    chk("h3_valid", {31'd0, instr_valid}, 32'd0);
    chk("h3_imem_a", imem_a, 32'h1E8);
    chk("h3_halt", {31'd0, halt}, 32'd1);
    redir(32'h0);
    chk("hr_halt", {31'd0, halt}, 32'd0);
    step();
    chk("hr_instr", instr, 32'hE3A0_00AA);

    // Fetch address wraps past the top of memory.
    redir(32'hFFFF_FFFC);
    chk("w_imem_a", imem_a, 32'hFFFF_FFFC);
    step();
    chk("w_pc", instr_pc, 32'hFFFF_FFFC);
    chk("w_wrap", imem_a, 32'h0);

    // Full queue with halt set, then async reset.
    instr_ready = 1'b0;
    redir(32'h1DC);
    for (int i = 0; i < 6; i++) step();
    chk("fh_halt", {31'd0, halt}, 32'd1);
    chk("fh_head", instr_pc, 32'h1DC);
    chk("fh_imem_a", imem_a, 32'h1E8);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_valid", {31'd0, instr_valid}, 32'd0);
    chk("ar_halt", {31'd0, halt}, 32'd0);
    chk("ar_imem_a", imem_a, 32'h0);
    step();
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
